// File: rtl/uart_frame_ctrl_if.sv
// Byte-stream input and register-write output bundle of the UART frame controller.
// The slave modport is the controller's view; master is the view of whoever drives the byte stream.
interface uart_frame_ctrl_if;
  logic       rx_data_vld;
  logic [7:0] rx_data;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_done;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  modport master (
    output rx_data_vld, rx_data,
    input  wr_en, wr_addr, wr_data, frame_done, frame_err, err_code, busy
  );

  modport slave (
    input  rx_data_vld, rx_data,
    output wr_en, wr_addr, wr_data, frame_done, frame_err, err_code, busy
  );
endinterface

// File: rtl/uart_frame_ctrl.sv
// Receive-side frame parser: buffers HEADER/ADDR/LEN/payload/CHK frames, verifies the
// checksum and replays good frames as a gapless burst of register writes.
module uart_frame_ctrl #(
  parameter int unsigned CLOCK         = 50_000_000,
  parameter int unsigned BAUD          = 9600,
  parameter logic [7:0]  HEADER        = 8'hAA,
  parameter int unsigned MAX_LEN       = 8,
  parameter int unsigned TIMEOUT_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  uart_frame_ctrl_if.slave  bus
);

  localparam int unsigned IDX_W     = $clog2(MAX_LEN + 1);
  localparam int unsigned BUF_AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned BUF_DEPTH = 1 << BUF_AW;
  localparam int unsigned TO_LIMIT  = TIMEOUT_BYTES * 10 * (CLOCK / BAUD);
  localparam int unsigned TO_W      = (TO_LIMIT > 1) ? $clog2(TO_LIMIT) : 1;

  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_LIMIT - 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [TO_W-1:0]  TO_ONE    = TO_W'(1);

  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_CHK,
    S_WRITE
  } state_t;

  state_t           state_q;
  logic [7:0]       base_q;
  logic [7:0]       sum_q;
  logic [IDX_W-1:0] len_q;
  logic [IDX_W-1:0] idx_q;
  logic [TO_W-1:0]  to_cnt_q;

  logic             wr_en_q;
  logic [7:0]       wr_addr_q;
  logic [7:0]       wr_data_q;
  logic             frame_done_q;
  logic             frame_err_q;
  logic [1:0]       err_code_q;
  logic             busy_q;

  logic [7:0]       buf_q [BUF_DEPTH];

  logic             vld;
  logic [7:0]       rxd;
  logic             in_frame;

  assign vld      = bus.rx_data_vld;
  assign rxd      = bus.rx_data;
  assign in_frame = (state_q == S_ADDR) || (state_q == S_LEN) ||
                    (state_q == S_DATA) || (state_q == S_CHK);

  // NOTE: the payload buffer carries no reset; each entry is written in DATA before WRITE reads it.
  always_ff @(posedge clk) begin
    if (state_q == S_DATA && vld) begin
      buf_q[idx_q[BUF_AW-1:0]] <= rxd;
    end
  end

  // NOTE: all state and outputs use <=, so every read in this block sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      sum_q        <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      to_cnt_q     <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_code_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= (state_q != S_IDLE);

      // Inter-byte timeout; a strobe in the expiry cycle wins and restarts the count.
      if (in_frame && !vld) begin
        if (to_cnt_q == TO_LAST) begin
          to_cnt_q    <= '0;
          state_q     <= S_IDLE;
          frame_err_q <= 1'b1;
          err_code_q  <= ERR_TIMEOUT;
        end else begin
          to_cnt_q <= to_cnt_q + TO_ONE;
        end
      end else begin
        to_cnt_q <= '0;
      end

      case (state_q)
        S_IDLE: begin
          if (vld && rxd == HEADER) begin
            state_q <= S_ADDR;
          end
        end

        S_ADDR: begin
          if (vld) begin
            base_q  <= rxd;
            sum_q   <= rxd;
            state_q <= S_LEN;
          end
        end

        S_LEN: begin
          if (vld) begin
            if (rxd == 8'd0 || rxd > MAX_LEN_B) begin
              state_q     <= S_IDLE;
              frame_err_q <= 1'b1;
              err_code_q  <= ERR_LEN;
            end else begin
              len_q   <= rxd[IDX_W-1:0];
              sum_q   <= sum_q + rxd;
              idx_q   <= '0;
              state_q <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (vld) begin
            sum_q <= sum_q + rxd;
            idx_q <= idx_q + IDX_ONE;
            if (idx_q == len_q - IDX_ONE) begin
              state_q <= S_CHK;
            end
          end
        end

        S_CHK: begin
          if (vld) begin
            if (rxd != sum_q) begin
              state_q     <= S_IDLE;
              frame_err_q <= 1'b1;
              err_code_q  <= ERR_CHK;
            end else begin
              // First write issues on the checksum edge so the burst starts one cycle after the strobe.
              wr_en_q   <= 1'b1;
              wr_addr_q <= base_q;
              wr_data_q <= buf_q[0];
              idx_q     <= IDX_ONE;
              if (len_q == IDX_ONE) begin
                frame_done_q <= 1'b1;
                state_q      <= S_IDLE;
              end else begin
                state_q <= S_WRITE;
              end
            end
          end
        end

        S_WRITE: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= base_q + 8'(idx_q);
          wr_data_q <= buf_q[idx_q[BUF_AW-1:0]];
          idx_q     <= idx_q + IDX_ONE;
          if (idx_q == len_q - IDX_ONE) begin
            frame_done_q <= 1'b1;
            state_q      <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.err_code   = err_code_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Self-checking bench for uart_frame_ctrl: directed frames plus a randomized frame stream,
// compared event-by-event (with cycle stamps) against a frame-parsing reference model.
`timescale 1ns/1ps
module tb_uart_frame_ctrl;

  localparam int unsigned CLOCK         = 1000;
  localparam int unsigned BAUD          = 100;
  localparam int unsigned MAX_LEN       = 8;
  localparam int unsigned TIMEOUT_BYTES = 4;
  localparam logic [7:0]  HEADER        = 8'hAA;
  localparam int          LIMIT         = TIMEOUT_BYTES * 10 * (CLOCK / BAUD);

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_frame_ctrl_if bus ();

  uart_frame_ctrl #(
    .CLOCK         (CLOCK),
    .BAUD          (BAUD),
    .HEADER        (HEADER),
    .MAX_LEN       (MAX_LEN),
    .TIMEOUT_BYTES (TIMEOUT_BYTES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_err;
    logic       wr;
    logic [1:0] code;
    logic [7:0] addr;
    logic [7:0] data;
    logic       done;
    int         cyc;
  } ev_t;

  ev_t        obs_q[$];
  ev_t        exp_q[$];
  logic [7:0] st_q[$];
  int         sc_q[$];
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  function automatic ev_t mk(logic is_err, logic wr, logic [1:0] code, logic [7:0] addr,
                             logic [7:0] data, logic done, int c);
    ev_t e;
    e.is_err = is_err;
    e.wr     = wr;
    e.code   = code;
    e.addr   = addr;
    e.data   = data;
    e.done   = done;
    e.cyc    = c;
    return e;
  endfunction

  function automatic string fmt(ev_t e);
    return $sformatf("{err=%0b wr=%0b code=%0d addr=%h data=%h done=%0b cyc=%0d}",
                     e.is_err, e.wr, e.code, e.addr, e.data, e.done, e.cyc);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: every write/done and every error pulse, stamped with the cycle it was seen.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wr_en || bus.frame_done)
        obs_q.push_back(mk(1'b0, bus.wr_en, 2'd0, bus.wr_addr, bus.wr_data, bus.frame_done, cyc));
      if (bus.frame_err)
        obs_q.push_back(mk(1'b1, 1'b0, bus.err_code, 8'h00, 8'h00, 1'b0, cyc));
    end
  end

  // Reference model: parse the logged byte stream frame by frame. An error or the first
  // write appears in the strobe's own stamp; write k at +k; a timeout LIMIT cycles after the last byte.
  function automatic void build_expected(input bit idle_tail);
    int         i;
    int         n;
    int         len;
    int         ci;
    logic [7:0] addr;
    logic [7:0] sum;
    i = 0;
    n = st_q.size();
    exp_q.delete();
    while (i < n) begin
      if (st_q[i] != HEADER) begin
        i++;
        continue;
      end
      if (i + 2 >= n) begin
        if (idle_tail) exp_q.push_back(mk(1'b1, 1'b0, 2'd3, 8'h00, 8'h00, 1'b0, sc_q[n-1] + LIMIT));
        break;
      end
      addr = st_q[i+1];
      len  = int'(st_q[i+2]);
      if (len == 0 || len > int'(MAX_LEN)) begin
        exp_q.push_back(mk(1'b1, 1'b0, 2'd1, 8'h00, 8'h00, 1'b0, sc_q[i+2]));
        i += 3;
        continue;
      end
      ci = i + 3 + len;
      if (ci >= n) begin
        if (idle_tail) exp_q.push_back(mk(1'b1, 1'b0, 2'd3, 8'h00, 8'h00, 1'b0, sc_q[n-1] + LIMIT));
        break;
      end
      sum = addr + st_q[i+2];
      for (int k = 0; k < len; k++) sum = sum + st_q[i+3+k];
      if (st_q[ci] != sum) begin
        exp_q.push_back(mk(1'b1, 1'b0, 2'd2, 8'h00, 8'h00, 1'b0, sc_q[ci]));
      end else begin
        for (int k = 0; k < len; k++)
          exp_q.push_back(mk(1'b0, 1'b1, 2'd0, addr + 8'(k), st_q[i+3+k], (k == len - 1), sc_q[ci] + k));
      end
      i = ci + 1;
    end
  endfunction

  task automatic clear_logs();
    obs_q.delete();
    exp_q.delete();
    st_q.delete();
    sc_q.delete();
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus.rx_data_vld = 1'b1;
    bus.rx_data     = b;
    @(negedge clk);
    bus.rx_data_vld = 1'b0;
    bus.rx_data     = 8'($urandom);
    st_q.push_back(b);
    sc_q.push_back(cyc);
  endtask

  // Sends the n low-order bytes of v, most significant first.
  task automatic send_vec(input logic [127:0] v, input int n, input int max_gap);
    for (int k = 0; k < n; k++)
      send_byte(v[8*(n-1-k) +: 8], $urandom_range(0, max_gap));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({bus.wr_en, bus.frame_done, bus.frame_err, bus.busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_strobes: got wr_en/done/err/busy=%b, expected 0000",
               {bus.wr_en, bus.frame_done, bus.frame_err, bus.busy});
    end
    n_tests++;
    if ({bus.wr_addr, bus.wr_data, bus.err_code} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_values: got addr=%h data=%h code=%0d, expected all 0",
               bus.wr_addr, bus.wr_data, bus.err_code);
    end
    rst = 1'b0;
    settle(2);
  endtask

  task automatic test_good_frame();
    clear_logs();
    send_vec(128'hAA_10, 2, 2);
    n_tests++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL good_busy_mid: got %b, expected 1", bus.busy);
    end
    send_vec(128'h02_11_22_45, 4, 2);
    settle(MAX_LEN + 4);
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL good_busy_end: got %b, expected 0", bus.busy);
    end
    build_expected(1'b0);
    n_tests++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL good_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL good_event%0d: got %s, expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
  endtask

  task automatic test_checksum_error();
    clear_logs();
    send_vec(128'hAA_10_02_11_22_46, 6, 3);
    settle(MAX_LEN + 4);
    build_expected(1'b0);
    n_tests++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL chk_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL chk_event%0d: got %s, expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
    n_tests++;
    if ({bus.busy, bus.err_code} !== 3'b0_10) begin
      n_fail++;
      $display("FAIL chk_status: got busy=%b code=%0d, expected busy=0 code=2", bus.busy, bus.err_code);
    end
  endtask

  task automatic test_bad_length();
    clear_logs();
    send_vec(128'hAA_05_00, 3, 2);
    settle(4);
    send_vec(128'hAA_05_09, 3, 2);
    settle(4);
    n_tests++;
    if (bus.err_code !== 2'd1) begin
      n_fail++;
      $display("FAIL len_code: got %0d, expected 1", bus.err_code);
    end
    send_vec(128'hAA_20_01_7F_A0, 5, 2);
    settle(MAX_LEN + 4);
    build_expected(1'b0);
    n_tests++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL len_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL len_event%0d: got %s, expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
    n_tests++;
    if (bus.err_code !== 2'd1) begin
      n_fail++;
      $display("FAIL len_code_held: got %0d, expected 1", bus.err_code);
    end
  endtask

  task automatic test_timeout();
    clear_logs();
    send_vec(128'hAA_10_02_11, 4, 3);
    settle(LIMIT + 20);
    build_expected(1'b1);
    n_tests++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL timeout_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL timeout_event%0d: got %s, expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
    n_tests++;
    if ({bus.busy, bus.err_code} !== 3'b0_11) begin
      n_fail++;
      $display("FAIL timeout_status: got busy=%b code=%0d, expected busy=0 code=3", bus.busy, bus.err_code);
    end
    clear_logs();
    send_vec(128'hAA_10_01_05_16, 5, 3);
    settle(MAX_LEN + 4);
    build_expected(1'b0);
    n_tests++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL timeout_next_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL timeout_next_event%0d: got %s, expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
  endtask

  task automatic test_addr_wrap_max_len();
    clear_logs();
    send_vec(128'hAA_FE_08_01_02_03_04_05_06_07_08_2A, 12, 2);
    settle(MAX_LEN + 4);
    build_expected(1'b0);
    n_tests++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL wrap_event%0d: got %s, expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
  endtask

  task automatic test_random_stream();
    for (int it = 0; it < 40; it++) begin
      logic [7:0] seg[$];
      logic [7:0] a;
      logic [7:0] l;
      logic [7:0] s;
      logic [7:0] b;
      int         kind;
      clear_logs();
      kind = $urandom_range(0, 3);
      if (kind == 3) begin
        for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
          b = 8'($urandom);
          if (b == HEADER) b = 8'h55;
          seg.push_back(b);
        end
      end
      a = 8'($urandom);
      if (kind == 2) l = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255));
      else           l = 8'($urandom_range(1, MAX_LEN));
      seg.push_back(HEADER);
      seg.push_back(a);
      seg.push_back(l);
      s = a + l;
      if (kind != 2) begin
        for (int j = 0; j < int'(l); j++) begin
          b = ($urandom_range(0, 3) == 0) ? HEADER : 8'($urandom);
          seg.push_back(b);
          s = s + b;
        end
        seg.push_back((kind == 1) ? s + 8'($urandom_range(1, 255)) : s);
      end
      foreach (seg[j]) send_byte(seg[j], $urandom_range(0, 4));
      settle(MAX_LEN + 4);
      build_expected(1'b0);
      n_tests++;
      if (obs_q.size() !== exp_q.size()) begin
        n_fail++;
        $display("FAIL rand%0d_count: got %0d events, expected %0d", it, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_tests++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL rand%0d_event%0d: got %s, expected %s", it, i, fmt(obs_q[i]), fmt(exp_q[i]));
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_logs();
    send_vec(128'h55_AA_10, 3, 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if ({bus.busy, bus.err_code, bus.frame_err, bus.wr_en} !== 5'b0) begin
      n_fail++;
      $display("FAIL midrst_status: got busy=%b code=%0d err=%b wr_en=%b, expected all 0",
               bus.busy, bus.err_code, bus.frame_err, bus.wr_en);
    end
    settle(LIMIT + 10);
    n_tests++;
    if (obs_q.size() !== 0) begin
      n_fail++;
      $display("FAIL midrst_aborted: got %0d events after reset, expected 0", obs_q.size());
    end
    clear_logs();
    send_vec(128'hAA_10_01_33_44, 5, 2);
    settle(MAX_LEN + 4);
    build_expected(1'b0);
    n_tests++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL midrst_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL midrst_event%0d: got %s, expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run still active at %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    bus.rx_data_vld = 1'b0;
    bus.rx_data     = 8'h00;
    test_reset();
    test_good_frame();
    test_checksum_error();
    test_bad_length();
    test_timeout();
    test_addr_wrap_max_len();
    test_random_stream();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
